keypad_lock_ctrl: RTL and testbench

- Sequencing controller for the doorlock keypad path. Consumes the one-hot 0..9 digit lines from the BCD-to-decimal decoder plus a key strobe.
- Collects a fixed-length code and compares it against a stored password. Drives unlock, failure and alarm outputs, with a lockout after repeated failures.
- Supports a password change while the lock is open.
- Sits between the keypad decoder and the lock actuator/indicator logic.

---
 rtl/keypad_lock_ctrl_if.sv | 26 ++
 rtl/keypad_lock_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_lock_ctrl_if.sv
// Keypad lock controller bus: key strobes and control requests toward the
// controller, lock/indicator status back from it. The keypad side (or a
// bench) uses the master modport, the controller uses the slave modport.
interface keypad_lock_ctrl_if;
    logic       key_valid;
    logic [9:0] key_dec;
    logic       clear;
    logic       set_req;
    logic       unlock;
    logic       bad_pulse;
    logic       alarm;
    logic       set_done;
    logic       key_err;
    logic [3:0] digit_cnt;
    logic [2:0] state_o;

    modport master (
        output key_valid, key_dec, clear, set_req,
        input  unlock, bad_pulse, alarm, set_done, key_err, digit_cnt, state_o
    );

    modport slave (
        input  key_valid, key_dec, clear, set_req,
        output unlock, bad_pulse, alarm, set_done, key_err, digit_cnt, state_o
    );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock sequencing controller.
// Collects DIGITS one-hot keys into a packed BCD buffer, compares the code
// against the stored password, drives unlock / bad_pulse / alarm, locks out
// after MAX_FAIL consecutive failures and allows a password change from OPEN.
// Optional entry timeout is compiled in with `define KEYPAD_TIMEOUT_EN.
module keypad_lock_ctrl #(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] PW_DEFAULT  = 16'h1234,
    parameter int                  OPEN_CYCLES = 8,
    parameter int                  LOCK_CYCLES = 16,
    parameter int                  MAX_FAIL    = 3
`ifdef KEYPAD_TIMEOUT_EN
    ,
    parameter int                  TIMEOUT_CYCLES = 64
`endif
) (
    input  logic               clk,
    input  logic               rst,
    keypad_lock_ctrl_if.slave  bus
);

    localparam int BUF_W = 4 * DIGITS;
    localparam int MAX_OL = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
`ifdef KEYPAD_TIMEOUT_EN
    localparam int MAX_T = (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
`else
    localparam int MAX_T = MAX_OL;
`endif
    localparam int TMR_W = $clog2(MAX_T + 1);

    // Timer holds "cycles remaining minus one" so the state leaves on the
    // edge where it reads zero, giving exactly N cycles in the state.
    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
`ifdef KEYPAD_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
    localparam logic [3:0]       DIGITS_C  = 4'(DIGITS);
    localparam logic [2:0]       MAXF_C    = 3'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5,
        S_SET     = 3'd6
    } state_t;

    state_t            state_q;
    logic [BUF_W-1:0]  pw_q;
    logic [BUF_W-1:0]  buf_q;
    logic [3:0]        cnt_q;
    logic [2:0]        fail_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              unlock_q;
    logic              bad_q;
    logic              alarm_q;
    logic              setdone_q;
    logic              keyerr_q;

    logic              key_onehot;
    logic [3:0]        key_digit;
    logic              key_acc;
    logic [BUF_W-1:0]  buf_shift_d;
    logic [3:0]        cnt_d;
    logic              last_key;
    logic [2:0]        fail_d;

    // Encode the one-hot digit lines to a BCD digit value.
    always_comb begin
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (bus.key_dec[i]) key_digit = 4'(i);
        end
    end

    assign key_onehot = (bus.key_dec != 10'd0) &&
                        ((bus.key_dec & (bus.key_dec - 10'd1)) == 10'd0);
    assign key_acc    = bus.key_valid && key_onehot &&
                        ((state_q == S_IDLE) || (state_q == S_ENTRY) || (state_q == S_SET));
    assign cnt_d      = cnt_q + 4'd1;
    assign last_key   = (cnt_d == DIGITS_C);
    assign fail_d     = fail_q + 3'd1;

    // New digit enters the LS nibble; a single-digit code has nothing to shift.
    if (DIGITS == 1) begin : g_shift_one
        assign buf_shift_d = key_digit;
    end else begin : g_shift_many
        assign buf_shift_d = {buf_q[BUF_W-5:0], key_digit};
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pw_q      <= PW_DEFAULT;
            buf_q     <= '0;
            cnt_q     <= 4'd0;
            fail_q    <= 3'd0;
            tmr_q     <= '0;
            unlock_q  <= 1'b0;
            bad_q     <= 1'b0;
            alarm_q   <= 1'b0;
            setdone_q <= 1'b0;
            keyerr_q  <= 1'b0;
        end else begin
            bad_q     <= 1'b0;
            setdone_q <= 1'b0;
            keyerr_q  <= bus.key_valid && !key_onehot;

            case (state_q)
                S_IDLE: begin
                    if (key_acc) begin
                        buf_q   <= buf_shift_d;
                        cnt_q   <= cnt_d;
                        state_q <= last_key ? S_CHECK : S_ENTRY;
`ifdef KEYPAD_TIMEOUT_EN
                        tmr_q   <= TO_LOAD;
`endif
                    end
                end

                S_ENTRY: begin
                    if (bus.clear) begin
                        buf_q   <= '0;
                        cnt_q   <= 4'd0;
                        state_q <= S_IDLE;
                    end else if (key_acc) begin
                        buf_q <= buf_shift_d;
                        cnt_q <= cnt_d;
                        if (last_key) state_q <= S_CHECK;
`ifdef KEYPAD_TIMEOUT_EN
                        tmr_q <= TO_LOAD;
`endif
                    end
`ifdef KEYPAD_TIMEOUT_EN
                    else if (tmr_q == '0) begin
                        buf_q   <= '0;
                        cnt_q   <= 4'd0;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
`endif
                end

                S_CHECK: begin
                    buf_q <= '0;
                    cnt_q <= 4'd0;
                    if (buf_q == pw_q) begin
                        fail_q   <= 3'd0;
                        unlock_q <= 1'b1;
                        tmr_q    <= OPEN_LOAD;
                        state_q  <= S_OPEN;
                    end else begin
                        fail_q <= fail_d;
                        bad_q  <= 1'b1;
                        if (fail_d == MAXF_C) begin
                            alarm_q <= 1'b1;
                            tmr_q   <= LOCK_LOAD;
                            state_q <= S_LOCKOUT;
                        end else begin
                            state_q <= S_FAIL;
                        end
                    end
                end

                S_OPEN: begin
                    if (bus.set_req) begin
                        unlock_q <= 1'b0;
                        state_q  <= S_SET;
`ifdef KEYPAD_TIMEOUT_EN
                        tmr_q    <= TO_LOAD;
`endif
                    end else if (tmr_q == '0) begin
                        unlock_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end

                S_FAIL: begin
                    state_q <= S_IDLE;
                end

                S_LOCKOUT: begin
                    if (tmr_q == '0) begin
                        alarm_q <= 1'b0;
                        fail_q  <= 3'd0;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end

                S_SET: begin
                    if (bus.clear) begin
                        buf_q   <= '0;
                        cnt_q   <= 4'd0;
                        state_q <= S_IDLE;
                    end else if (key_acc) begin
                        if (last_key) begin
                            pw_q      <= buf_shift_d;
                            buf_q     <= '0;
                            cnt_q     <= 4'd0;
                            setdone_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            buf_q <= buf_shift_d;
                            cnt_q <= cnt_d;
`ifdef KEYPAD_TIMEOUT_EN
                            tmr_q <= TO_LOAD;
`endif
                        end
                    end
`ifdef KEYPAD_TIMEOUT_EN
                    else if (tmr_q == '0) begin
                        buf_q   <= '0;
                        cnt_q   <= 4'd0;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
`endif
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.unlock    = unlock_q;
    assign bus.bad_pulse = bad_q;
    assign bus.alarm     = alarm_q;
    assign bus.set_done  = setdone_q;
    assign bus.key_err   = keyerr_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Scoreboard bench for keypad_lock_ctrl: stimulus pushes expected output
// pulses (kind, first high cycle, length) into a queue; a monitor pops and
// compares each pulse when it ends. Static state checks are made inline.
`timescale 1ns/1ps
module tb_keypad_lock_ctrl;

    localparam int EV_UNLOCK  = 0;
    localparam int EV_BAD     = 1;
    localparam int EV_ALARM   = 2;
    localparam int EV_SETDONE = 3;
    localparam int EV_KEYERR  = 4;

    typedef struct {
        int kind;
        int start;
        int len;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   last_edge = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    keypad_lock_ctrl_if bus ();

    keypad_lock_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic string kname(input int k);
        case (k)
            EV_UNLOCK:  return "unlock";
            EV_BAD:     return "bad_pulse";
            EV_ALARM:   return "alarm";
            EV_SETDONE: return "set_done";
            default:    return "key_err";
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int start, input int len);
        ev_t e;
        e.kind  = kind;
        e.start = start;
        e.len   = len;
        exp_q.push_back(e);
    endtask

    // Monitor: track pulse runs on each output and score them when they end.
    initial begin
        int   run_len[5];
        int   run_start[5];
        logic [4:0] sig;
        ev_t  e;
        for (int k = 0; k < 5; k++) begin
            run_len[k]   = 0;
            run_start[k] = 0;
        end
        forever begin
            @(negedge clk);
            sig = {bus.key_err, bus.set_done, bus.alarm, bus.bad_pulse, bus.unlock};
            for (int k = 0; k < 5; k++) begin
                if (sig[k] === 1'b1) begin
                    if (run_len[k] == 0) run_start[k] = cyc;
                    run_len[k]++;
                end else if (run_len[k] > 0) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL event_%s: got start=%0d len=%0d, expected no event",
                                 kname(k), run_start[k], run_len[k]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.start != run_start[k] || e.len != run_len[k]) begin
                            fails++;
                            $display("FAIL event_%s: got %s start=%0d len=%0d, expected %s start=%0d len=%0d",
                                     kname(k), kname(k), run_start[k], run_len[k],
                                     kname(e.kind), e.start, e.len);
                        end
                    end
                    run_len[k] = 0;
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic raw_key(input logic [9:0] v);
        bus.key_valid = 1'b1;
        bus.key_dec   = v;
        last_edge     = cyc + 1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_dec   = 10'd0;
    endtask

    task automatic press(input int d);
        logic [9:0] v;
        v    = 10'd0;
        v[d] = 1'b1;
        raw_key(v);
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    // Directed stimulus.
    initial begin
        int n;
        rst           = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_dec   = 10'd0;
        bus.clear     = 1'b0;
        bus.set_req   = 1'b0;
        idle(2);
        chk("reset_state", int'(bus.state_o), 0);
        chk("reset_digit_cnt", int'(bus.digit_cnt), 0);
        chk("reset_outputs", int'({bus.unlock, bus.bad_pulse, bus.alarm, bus.set_done, bus.key_err}), 0);
        rst = 1'b0;
        idle(1);

        // Correct code opens for OPEN_CYCLES, starting two cycles after the last key.
        enter4(1, 2, 3, 4);
        n = last_edge;
        expect_ev(EV_UNLOCK, n + 1, 8);
        chk("check_after_last_key", int'(bus.state_o), 2);
        idle(10);
        chk("idle_after_open", int'(bus.state_o), 0);

        // Two wrong attempts, then lockout on the third.
        repeat (2) begin
            enter4(1, 2, 3, 5);
            expect_ev(EV_BAD, last_edge + 1, 1);
            idle(3);
            chk("idle_after_fail", int'(bus.state_o), 0);
        end
        enter4(1, 2, 3, 5);
        n = last_edge;
        expect_ev(EV_BAD, n + 1, 1);
        expect_ev(EV_ALARM, n + 1, 16);
        idle(2);
        chk("lockout_state", int'(bus.state_o), 5);
        press(5);
        chk("lockout_key_ignored", int'(bus.digit_cnt), 0);
        chk("lockout_alarm", int'(bus.alarm), 1);
        idle(16);
        chk("idle_after_lockout", int'(bus.state_o), 0);
        enter4(1, 2, 3, 4);
        expect_ev(EV_UNLOCK, last_edge + 1, 8);
        idle(10);

        // Clear wins over a same-cycle key.
        press(1);
        press(2);
        chk("entry_cnt_2", int'(bus.digit_cnt), 2);
        bus.clear     = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_dec   = 10'b10_0000_0000;
        @(negedge clk);
        bus.clear     = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_dec   = 10'd0;
        chk("clear_cnt", int'(bus.digit_cnt), 0);
        chk("clear_state", int'(bus.state_o), 0);
        enter4(1, 2, 3, 4);
        expect_ev(EV_UNLOCK, last_edge + 1, 8);
        idle(10);

        // Password change from OPEN.
        enter4(1, 2, 3, 4);
        n = last_edge;
        idle(2);
        chk("open_state", int'(bus.state_o), 3);
        bus.set_req = 1'b1;
        expect_ev(EV_UNLOCK, n + 1, (cyc + 1) - (n + 1));
        @(negedge clk);
        bus.set_req = 1'b0;
        chk("set_state", int'(bus.state_o), 6);
        chk("set_unlock_low", int'(bus.unlock), 0);
        enter4(9, 8, 7, 6);
        expect_ev(EV_SETDONE, last_edge, 1);
        chk("idle_after_set", int'(bus.state_o), 0);
        idle(2);
        enter4(1, 2, 3, 4);
        expect_ev(EV_BAD, last_edge + 1, 1);
        idle(3);
        enter4(9, 8, 7, 6);
        expect_ev(EV_UNLOCK, last_edge + 1, 8);
        idle(10);

        // Malformed keys flag key_err and leave the entry untouched.
        press(1);
        raw_key(10'b00_0000_0011);
        expect_ev(EV_KEYERR, last_edge, 1);
        chk("keyerr_multi_cnt", int'(bus.digit_cnt), 1);
        idle(1);
        raw_key(10'b00_0000_0000);
        expect_ev(EV_KEYERR, last_edge, 1);
        chk("keyerr_zero_cnt", int'(bus.digit_cnt), 1);
        chk("keyerr_state", int'(bus.state_o), 1);
        idle(1);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_after_keyerr", int'(bus.digit_cnt), 0);

        // Reset in OPEN drops unlock and restores the default password.
        enter4(9, 8, 7, 6);
        n = last_edge;
        idle(3);
        rst = 1'b1;
        expect_ev(EV_UNLOCK, n + 1, (cyc + 1) - (n + 1));
        @(negedge clk);
        rst = 1'b0;
        chk("rst_unlock", int'(bus.unlock), 0);
        chk("rst_state", int'(bus.state_o), 0);
        enter4(1, 2, 3, 4);
        expect_ev(EV_UNLOCK, last_edge + 1, 8);
        idle(10);
        enter4(9, 8, 7, 6);
        expect_ev(EV_BAD, last_edge + 1, 1);
        idle(3);

`ifdef KEYPAD_TIMEOUT_EN
        // Entry timeout: a key in the last cycle keeps the entry alive.
        press(1);
        press(2);
        idle(63);
        press(3);
        chk("timeout_reload_state", int'(bus.state_o), 1);
        chk("timeout_reload_cnt", int'(bus.digit_cnt), 3);
        idle(63);
        chk("timeout_not_yet", int'(bus.state_o), 1);
        idle(1);
        chk("timeout_state", int'(bus.state_o), 0);
        chk("timeout_cnt", int'(bus.digit_cnt), 0);
        idle(3);
`endif

        idle(5);
        chk("pending_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
